// File: rtl/car_spawner.sv
// rtl/car_spawner.sv - per-lane LFSR-paced car spawn scheduler with round-robin lane grant
// Optional: define SPAWN_DIFFICULTY_EN to shrink the reload base as SpawnCount grows.
module car_spawner #(
  parameter int          NUM_LANES = 4,
  parameter int          MIN_GAP   = 30,
  parameter int          GAP_BITS  = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 FrameClk,
  input  logic                 Reset,
  input  logic                 SpawnEnable,
  input  logic [NUM_LANES-1:0] SlotFree,
  output logic [NUM_LANES-1:0] SpawnReq,
  output logic [2:0]           SpawnLane,
  output logic [2:0]           SpawnSpeed,
  output logic [7:0]           SpawnCount
);

  localparam logic [7:0] GAP0 = 8'(MIN_GAP);

  logic [7:0]           cnt [NUM_LANES];
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_next;
  logic [2:0]           rr;
  logic                 en_q;
  logic [NUM_LANES-1:0] elig;
  logic                 hit;
  logic [2:0]           grant;
  logic [7:0]           base;
  logic [7:0]           reload;
  logic [7:0]           count_base;
`ifdef SPAWN_DIFFICULTY_EN
  logic [7:0]           dec;
`endif

  assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign count_base = en_q ? SpawnCount : 8'd0;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++)
      elig[i] = (cnt[i] == 8'd0) && SlotFree[i];
  end

  // Round-robin: first eligible lane at or after rr+1, wrapping.
  always_comb begin
    hit   = 1'b0;
    grant = 3'd0;
    for (int k = 1; k <= NUM_LANES; k++)
      for (int i = 0; i < NUM_LANES; i++)
        if (!hit && elig[i] && (i == (int'(rr) + k) % NUM_LANES)) begin
          hit   = 1'b1;
          grant = 3'(i);
        end
  end

  always_comb begin
`ifdef SPAWN_DIFFICULTY_EN
    dec = {4'd0, SpawnCount[7:4]};
    if (dec >= GAP0 - (GAP0 >> 1))
      base = GAP0 >> 1;
    else
      base = GAP0 - dec;
`else
    base = GAP0;
`endif
    reload = base + 8'(lfsr[GAP_BITS-1:0]);
  end

  always_ff @(posedge FrameClk) begin
    if (Reset) begin
      SpawnReq   <= '0;
      SpawnLane  <= 3'd0;
      SpawnSpeed <= 3'd0;
      SpawnCount <= 8'd0;
      lfsr       <= LFSR_SEED;
      rr         <= 3'(NUM_LANES - 1);
      en_q       <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++)
        cnt[i] <= GAP0;
    end else begin
      en_q     <= SpawnEnable;
      SpawnReq <= '0;
      if (!SpawnEnable) begin
        for (int i = 0; i < NUM_LANES; i++)
          cnt[i] <= GAP0;
      end else begin
        lfsr <= lfsr_next;
        for (int i = 0; i < NUM_LANES; i++) begin
          if (hit && (grant == 3'(i)))
            cnt[i] <= reload;
          else if (cnt[i] != 8'd0)
            cnt[i] <= cnt[i] - 8'd1;
        end
        if (hit) begin
          SpawnReq   <= {{(NUM_LANES-1){1'b0}}, 1'b1} << grant;
          SpawnLane  <= grant;
          SpawnSpeed <= {1'b0, lfsr[9:8]} + 3'd1;
          rr         <= grant;
          SpawnCount <= (count_base == 8'hFF) ? 8'hFF : count_base + 8'd1;
        end else begin
          SpawnCount <= count_base;
        end
      end
    end
  end

endmodule

// File: doc/car_spawner.md
Name: car_spawner

Overview:
- Consumes the round-level SpawnEnable produced by the game-state controller.
- Decides when and in which road lane a new car appears, and emits one spawn command per frame at most.
- Spawn commands go to the lane/sprite slot logic, which returns per-lane free-slot status.
- Timing is paced by per-lane frame countdowns reloaded with LFSR-randomised gaps.

Parameters:
- NUM_LANES, 4, number of road lanes; 2..8.
- MIN_GAP, 30, minimum frames between spawns in one lane; 1..191.
- GAP_BITS, 6, random extra gap range is 0..(2^GAP_BITS - 1) frames; MIN_GAP + 2^GAP_BITS - 1 <= 255.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- FrameClk  in  1  frame-rate clock (one edge per video frame).
- Reset  in  1  synchronous, active-high.
- SpawnEnable  in  1  high while a round is in progress.
- SlotFree  in  NUM_LANES  bit i high = lane i can accept a new car this frame.
- SpawnReq  out  NUM_LANES  one-hot, single-frame pulse commanding a spawn in that lane.
- SpawnLane  out  3  binary index of the lane in the current/last SpawnReq.
- SpawnSpeed  out  3  speed for the spawned car, 1..4.
- SpawnCount  out  8  cars spawned this round, saturating.

Behaviour:
- Reset and already-decided interface: Reset, synchronous, active-high; clock FrameClk.
- Reset values: SpawnReq=0, SpawnLane=0, SpawnSpeed=0, SpawnCount=0, every cnt[i]=MIN_GAP, LFSR=LFSR_SEED, round-robin pointer rr=NUM_LANES-1.
- All outputs are registered and change only on FrameClk edges.
- State is derived from SpawnEnable:
  - IDLE (SpawnEnable=0): SpawnReq=0. All cnt[i] are held at MIN_GAP. LFSR and rr hold.
  - RUN (SpawnEnable=1): per-edge rules below.
- Rising edge of SpawnEnable (previous-cycle register 0, current input 1): SpawnCount clears to 0 on that edge; a SpawnReq issued on the same edge counts as 1.
- LFSR: 16-bit Galois, mask 16'hB400, shift right. Advances once per RUN edge only. Never reaches 0.
- Counters, each RUN edge:
  - Every lane with cnt[i]!=0 decrements by 1.
  - A lane with cnt[i]==0 (pre-edge value) AND SlotFree[i]=1 is eligible.
- Grant:
  - Search eligible lanes starting at index rr+1, wrapping modulo NUM_LANES; take the first hit.
  - On grant g: SpawnReq=(1<<g) for exactly one cycle, SpawnLane=g, SpawnSpeed={1'b0,lfsr[9:8]}+1, rr=g, cnt[g]=MIN_GAP+lfsr[GAP_BITS-1:0].
  - All reads use the pre-edge LFSR value.
- No eligible lane: SpawnReq=0. SpawnLane and SpawnSpeed hold their last values.
- Lane at 0 with SlotFree=0: stays at 0 and is not eligible; no request is generated (waits, no drop).
- Several lanes eligible on the same edge: only one is granted; the rest stay at 0 and compete next frame.
- SpawnCount increments on each grant and saturates at 255.
- SpawnEnable falls mid-round: SpawnReq=0 from that edge on; counters reload to MIN_GAP; SpawnCount holds until the next rising edge.
- Reset mid-round overrides everything and returns all state to reset values.
- Latency: SpawnReq asserts the edge after a counter is seen at 0 with SlotFree=1.

Optional Feature:
- Macro: SPAWN_DIFFICULTY_EN.
- Defined: the reload base becomes max(MIN_GAP - (SpawnCount>>4), MIN_GAP>>1), so gaps tighten as more cars spawn.
- Undefined: the reload base is fixed at MIN_GAP.
- The IDLE hold value is MIN_GAP in both builds.

Test Plan:
- Reset, then SpawnEnable=1, SlotFree=4'b1111 (defaults) -> no SpawnReq for 30 edges; edges 31/32/33/34 give SpawnReq 0001/0010/0100/1000, SpawnLane 0..3, SpawnCount=4.
- As above but SlotFree=4'b1110 -> first grant is lane 1 at edge 31; lane 0 never granted; raise SlotFree[0] at edge 40 -> lane 0 granted at edge 41.
- SpawnEnable drops at edge 20 and re-rises at edge 25 -> no SpawnReq until 31 enabled edges after the re-rise; SpawnCount=0 at the re-rise.
- Run 2000 enabled frames with all slots free -> every per-lane inter-spawn gap lies in 30..93+contention; SpawnSpeed always 1..4; SpawnCount saturates at 255 and never wraps.
- Reset asserted on the edge a grant would occur -> SpawnReq=0 and all outputs at reset values next cycle.
- With SPAWN_DIFFICULTY_EN defined, SpawnCount=64 -> reload base=26; SpawnCount=255 -> base=15 (floor MIN_GAP>>1).
